// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: shared prescaler issuing physics/animation/scroll enable ticks
// and owning the run/pause/over sequencing plus score-driven scroll speed-up.
module game_tick_scheduler #(
   parameter int BASE_DIV       = 500000,
   parameter int PHYS_DIV       = 1,
   parameter int ANIM_DIV       = 10,
   parameter int SCROLL_DIV0    = 8,
   parameter int MIN_SCROLL_DIV = 2,
   parameter int SPEED_STEP     = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pause_toggle,
   input  logic       crash,
   input  logic       score_inc,
   output logic       tick_base,
   output logic       tick_phys,
   output logic       tick_anim,
   output logic       tick_scroll,
   output logic [3:0] speed_level,
   output logic [1:0] game_state
);
   localparam int PW = $clog2(BASE_DIV);
   localparam int MAX_LEVEL = (SCROLL_DIV0 - MIN_SCROLL_DIV) < 15 ? (SCROLL_DIV0 - MIN_SCROLL_DIV) : 15;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;
   state_t state;
   logic [PW-1:0] presc;
   logic [7:0] phys_cnt, anim_cnt, scroll_cnt, score_cnt, scroll_raw, scroll_div;
   logic strobe, enter, scoring, phys_wrap, anim_wrap, scroll_wrap, level_up;
   assign game_state = state;
   always_comb begin
      strobe = state == RUN && presc == PW'(BASE_DIV - 1);
      enter = start && (state == IDLE || state == OVER);
      scoring = state == RUN && score_inc;
      scroll_raw = 8'(SCROLL_DIV0) - {4'd0, speed_level};
      scroll_div = scroll_raw < 8'(MIN_SCROLL_DIV) ? 8'(MIN_SCROLL_DIV) : scroll_raw;
      phys_wrap = phys_cnt == 8'(PHYS_DIV - 1);
      anim_wrap = anim_cnt == 8'(ANIM_DIV - 1);
      // >= so a shrinking divisor never strands the counter above its new wrap point
      scroll_wrap = scroll_cnt >= scroll_div - 8'd1;
      level_up = score_cnt == 8'(SPEED_STEP - 1);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         presc <= '0;
         phys_cnt <= '0;
         anim_cnt <= '0;
         scroll_cnt <= '0;
         score_cnt <= '0;
         speed_level <= '0;
         tick_base <= 1'b0;
         tick_phys <= 1'b0;
         tick_anim <= 1'b0;
         tick_scroll <= 1'b0;
      end else begin
         tick_base <= strobe;
         tick_phys <= strobe && phys_wrap;
         tick_anim <= strobe && anim_wrap;
         tick_scroll <= strobe && scroll_wrap;
         if (enter) begin
            state <= RUN;
            presc <= '0;
            phys_cnt <= '0;
            anim_cnt <= '0;
            scroll_cnt <= '0;
            score_cnt <= '0;
            speed_level <= '0;
         end else begin
            if (state == RUN && crash) state <= OVER;
            else if (state == RUN && pause_toggle) state <= PAUSE;
            else if (state == PAUSE && pause_toggle) state <= RUN;
            if (state == RUN) presc <= strobe ? '0 : presc + 1'b1;
            if (strobe) begin
               phys_cnt <= phys_wrap ? 8'd0 : phys_cnt + 8'd1;
               anim_cnt <= anim_wrap ? 8'd0 : anim_cnt + 8'd1;
               scroll_cnt <= scroll_wrap ? 8'd0 : scroll_cnt + 8'd1;
            end
            if (scoring) begin
               score_cnt <= level_up ? 8'd0 : score_cnt + 8'd1;
               if (level_up && speed_level < 4'(MAX_LEVEL)) speed_level <= speed_level + 4'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb_game_tick_scheduler: directed phases with tick-time scoreboards per channel.
module tb_game_tick_scheduler;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause_toggle = 1'b0, crash = 1'b0, score_inc = 1'b0;
   logic tick_base, tick_phys, tick_anim, tick_scroll;
   logic [3:0] speed_level;
   logic [1:0] game_state;
   int cyc = 0, t0 = 0, errors = 0, checks = 0, me;
   int qb[$], qp[$], qa[$], qs[$];

   game_tick_scheduler #(.BASE_DIV(4), .PHYS_DIV(1), .ANIM_DIV(3), .SCROLL_DIV0(4),
                         .MIN_SCROLL_DIV(2), .SPEED_STEP(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pause_toggle(pause_toggle), .crash(crash),
      .score_inc(score_inc), .tick_base(tick_base), .tick_phys(tick_phys), .tick_anim(tick_anim),
      .tick_scroll(tick_scroll), .speed_level(speed_level), .game_state(game_state));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // each asserted tick must match the next expected cycle of its channel
   always @(negedge clk) begin
      if (tick_base) begin me = qb.size() > 0 ? qb.pop_front() : -1; check("tick_base", cyc - t0, me); end
      if (tick_phys) begin me = qp.size() > 0 ? qp.pop_front() : -1; check("tick_phys", cyc - t0, me); end
      if (tick_anim) begin me = qa.size() > 0 ? qa.pop_front() : -1; check("tick_anim", cyc - t0, me); end
      if (tick_scroll) begin me = qs.size() > 0 ? qs.pop_front() : -1; check("tick_scroll", cyc - t0, me); end
   end

   task automatic at(input int r);
      while (cyc - t0 < r) @(negedge clk);
   endtask

   task automatic go();
      start = 1'b1;
      t0 = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drained(input string tag);
      check(tag, qb.size() + qp.size() + qa.size() + qs.size(), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_state", game_state, 0);
      check("rst_level", speed_level, 0);
      check("rst_ticks", {tick_base, tick_phys, tick_anim, tick_scroll}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      pause_toggle = 1'b1; crash = 1'b1;
      @(negedge clk);
      pause_toggle = 1'b0; crash = 1'b0;
      @(negedge clk);
      check("idle_ignore", game_state, 0);
      // basic cadence at speed 0
      for (int k = 1; k <= 8; k++) begin qb.push_back(4 * k); qp.push_back(4 * k); end
      qa.push_back(12); qa.push_back(24); qs.push_back(16); qs.push_back(32);
      go();
      check("run_entry", game_state, 1);
      at(34);
      crash = 1'b1; @(negedge clk); crash = 1'b0;
      at(36);
      check("crash_over", game_state, 3);
      drained("drain_p1");
      // speed-up with saturation; crash in a strobe cycle leaves one trailing tick
      for (int k = 1; k <= 9; k++) begin qb.push_back(4 * k); qp.push_back(4 * k); end
      qa.push_back(12); qa.push_back(24); qa.push_back(36);
      for (int k = 1; k <= 4; k++) qs.push_back(8 * k);
      go();
      score_inc = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) check("level_1", speed_level, 1);
         if (i == 4) check("level_2", speed_level, 2);
         @(negedge clk);
      end
      score_inc = 1'b0;
      check("level_sat", speed_level, 2);
      at(35);
      crash = 1'b1; @(negedge clk); crash = 1'b0;
      check("over_trailing", game_state, 3);
      at(38);
      drained("drain_p2");
      check("level_hold_over", speed_level, 2);
      // pause/resume, ignored inputs, divisor change at the wrap point
      qb.push_back(4); qb.push_back(22); qb.push_back(26); qb.push_back(30);
      qp.push_back(4); qp.push_back(22); qp.push_back(26); qp.push_back(30);
      qa.push_back(26); qs.push_back(26);
      go();
      at(2);
      start = 1'b1; @(negedge clk); start = 1'b0;
      check("start_in_run", game_state, 1);
      at(6);
      pause_toggle = 1'b1; @(negedge clk); pause_toggle = 1'b0;
      check("paused", game_state, 2);
      at(10);
      score_inc = 1'b1; crash = 1'b1; start = 1'b1;
      @(negedge clk);
      crash = 1'b0; start = 1'b0;
      @(negedge clk);
      score_inc = 1'b0;
      check("pause_ignore_state", game_state, 2);
      check("pause_ignore_score", speed_level, 0);
      at(20);
      pause_toggle = 1'b1; @(negedge clk); pause_toggle = 1'b0;
      check("resumed", game_state, 1);
      at(23);
      score_inc = 1'b1; @(negedge clk); @(negedge clk); score_inc = 1'b0;
      check("level_after_resume", speed_level, 1);
      at(32);
      crash = 1'b1; pause_toggle = 1'b1;
      @(negedge clk);
      crash = 1'b0; pause_toggle = 1'b0;
      check("crash_priority", game_state, 3);
      at(43);
      drained("drain_p3");
      check("level_kept", speed_level, 1);
      // restart clears level, then asynchronous reset mid-run
      qb.push_back(4); qb.push_back(8); qp.push_back(4); qp.push_back(8);
      go();
      check("restart_state", game_state, 1);
      check("restart_level", speed_level, 0);
      at(1);
      score_inc = 1'b1; @(negedge clk); @(negedge clk); score_inc = 1'b0;
      check("level_pre_rst", speed_level, 1);
      at(8);
      #1 rst_n = 1'b0;
      #1;
      check("async_state", game_state, 0);
      check("async_level", speed_level, 0);
      check("async_ticks", {tick_base, tick_phys, tick_anim, tick_scroll}, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_idle", game_state, 0);
      drained("drain_p4");
      for (int k = 1; k <= 3; k++) begin qb.push_back(4 * k); qp.push_back(4 * k); end
      qa.push_back(12);
      go();
      at(14);
      drained("drain_p5");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      errors++;
      $display("FAIL timeout observed=%0d expected=0", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end
endmodule
